// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: frame width, idle line level and
// bit-period arithmetic, reused by the transmitter and receiver.
package uart_receiver_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Clock cycles per line bit (integer division).
    function automatic int uart_bit_period(input int clk_hz,
                                           input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports: clk, reset (sync, active-high), d (async in), q (synced out).
module bit_synchronizer #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: samples rx at bit centres, delivers bytes over
// valid/ready from a single-entry register, flags framing errors and
// overruns. Ports: clk, reset, rx, data_out, data_valid, data_ready,
// frame_error, overrun, busy.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int BAUD_RATE    = 9_600,
    parameter int SYS_CLK_FREQ = 48_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic                      frame_error,
    output logic                      overrun,
    output logic                      busy
);

    localparam int BIT_PERIOD = uart_bit_period(SYS_CLK_FREQ, BAUD_RATE);
    localparam int HALF       = BIT_PERIOD / 2;
    localparam int TW         = $clog2(BIT_PERIOD);
    localparam int IW         = $clog2(UART_DATA_BITS);
    localparam int DW         = UART_DATA_BITS;

    localparam logic [TW-1:0] TMR_FULL = TW'(BIT_PERIOD - 1);
    localparam logic [TW-1:0] TMR_HALF = TW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DW - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_e;

    logic rx_s;

    rx_state_e         state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     shift_q, shift_d;
    logic [DW-1:0]     data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              frame_error_q, frame_error_d;
    logic              overrun_q, overrun_d;
    logic              busy_q, busy_d;

    bit_synchronizer #(
        .RESET_VALUE (UART_IDLE_LEVEL)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q & ~data_ready;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_s != UART_IDLE_LEVEL) begin
                    state_d = S_START;
                    timer_d = TMR_HALF;
                end
            end
            S_START: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (rx_s == 1'b0) begin
                    state_d = S_DATA;
                    timer_d = TMR_FULL;
                    idx_d   = '0;
                end else begin
                    // Start bit vanished by mid-period: treat as glitch.
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    // LSB arrives first, so shift in from the top.
                    shift_d = {rx_s, shift_q[DW-1:1]};
                    timer_d = TMR_FULL;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (rx_s == 1'b1) begin
                    data_out_d   = shift_q;
                    data_valid_d = 1'b1;
                    // A byte consumed this same cycle is not an overrun.
                    overrun_d    = data_valid_q & ~data_ready;
                    state_d      = S_IDLE;
                end else begin
                    frame_error_d = 1'b1;
                    state_d       = S_BREAK;
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a stuck-low
                // line cannot retrigger a frame.
                if (rx_s == 1'b1) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames plus a randomised mix of
// good frames, glitches and framing errors against a byte-level model.
module tb_uart_receiver;

    localparam int BP   = 16;
    localparam int HALF = 8;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       rx         = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_receiver #(
        .BAUD_RATE    (10_000),
        .SYS_CLK_FREQ (160_000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int both_cnt = 0;
    int vcyc     = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      tag, got, exp);
    endtask

    // Handshake monitor: the values seen here are the ones the
    // next rising edge acts on.
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            if (data_valid && data_ready) got_q.push_back(data_out);
            if (frame_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_error && overrun) both_cnt++;
            if (data_valid) vcyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sample();
        #2;
    endtask

    task automatic send_bits(input logic [7:0] b);
        rx = 1'b0;
        tick(BP);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BP);
        end
    endtask

    task automatic stop_high(input bit pulse_ready);
        rx = 1'b1;
        if (pulse_ready) begin
            tick(10);
            data_ready = 1'b1;
            tick(1);
            data_ready = 1'b0;
            tick(BP - 11);
        end else begin
            tick(BP);
        end
    endtask

    int fe0, ov0, v0, exp_fe, n_exp;
    logic [7:0] rb;
    int kind, glen;

    initial begin
        // Reset state
        tick(3);
        sample();
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_fe", frame_error, 0);
        chk("rst_ov", overrun, 0);
        chk("rst_busy", busy, 0);
        tick(1);
        reset = 1'b0;
        tick(4);

        // Plain frame 0xA5 with consumer always ready
        data_ready = 1'b1;
        got_q.delete();
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc;
        send_bits(8'hA5);
        stop_high(1'b0);
        tick(2);
        sample();
        chk("a5_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("a5_byte", got_q[0], 8'hA5);
        chk("a5_vcyc", vcyc - v0, 1);
        chk("a5_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        chk("a5_busy", busy, 0);

        // Start glitch: line low for 4 cycles only
        tick(1);
        fe0 = fe_cnt; v0 = vcyc;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(10);
        sample();
        chk("glitch_busy", busy, 0);
        chk("glitch_vcyc", vcyc - v0, 0);
        chk("glitch_fe", fe_cnt - fe0, 0);

        // Framing error: 0x3C, stop held low for 3 bit periods
        tick(1);
        fe0 = fe_cnt; v0 = vcyc;
        send_bits(8'h3C);
        rx = 1'b0;
        tick(3 * BP);
        sample();
        chk("fe_busy_held", busy, 1);
        chk("fe_pulses", fe_cnt - fe0, 1);
        tick(1);
        rx = 1'b1;
        tick(BP);
        sample();
        chk("fe_busy_after", busy, 0);
        chk("fe_vcyc", vcyc - v0, 0);
        chk("fe_pulses_after", fe_cnt - fe0, 1);

        // Overrun: back-to-back 0x11, 0x22 with nobody consuming
        tick(1);
        data_ready = 1'b0;
        got_q.delete();
        ov0 = ov_cnt;
        send_bits(8'h11);
        stop_high(1'b0);
        sample();
        chk("ovr_first_valid", data_valid, 1);
        chk("ovr_first_byte", data_out, 8'h11);
        chk("ovr_first_ov", ov_cnt - ov0, 0);
        send_bits(8'h22);
        stop_high(1'b0);
        sample();
        chk("ovr_second_byte", data_out, 8'h22);
        chk("ovr_second_valid", data_valid, 1);
        chk("ovr_pulses", ov_cnt - ov0, 1);
        tick(1);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        tick(2);
        sample();
        chk("ovr_drain_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("ovr_drain_byte", got_q[0], 8'h22);
        chk("ovr_drain_valid", data_valid, 0);

        // Consume on the exact cycle the next byte lands
        tick(1);
        got_q.delete();
        ov0 = ov_cnt;
        send_bits(8'h33);
        stop_high(1'b0);
        send_bits(8'h44);
        stop_high(1'b1);
        sample();
        chk("same_valid", data_valid, 1);
        chk("same_byte", data_out, 8'h44);
        chk("same_ov", ov_cnt - ov0, 0);
        chk("same_taken", got_q.size(), 1);
        if (got_q.size() > 0) chk("same_taken_byte", got_q[0], 8'h33);
        tick(1);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        tick(2);

        // Reset during bit 4 of 0xFF while a byte is held
        send_bits(8'h77);
        stop_high(1'b0);
        rx = 1'b0;
        tick(BP);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            tick(BP);
        end
        rx = 1'b1;
        tick(HALF);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        sample();
        chk("mid_rst_data_out", data_out, 0);
        chk("mid_rst_valid", data_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_flags", {frame_error, overrun}, 0);
        tick(2 * BP);
        data_ready = 1'b1;
        got_q.delete();
        send_bits(8'h5A);
        stop_high(1'b0);
        tick(2);
        sample();
        chk("post_rst_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("post_rst_byte", got_q[0], 8'h5A);

        // Randomised mix against the byte-level model
        tick(1);
        got_q.delete();
        exp_q.delete();
        exp_fe = 0;
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc;
        for (int k = 0; k < 24; k++) begin
            kind = $urandom_range(0, 3);
            rb   = 8'($urandom);
            if (kind <= 1) begin
                send_bits(rb);
                stop_high(1'b0);
                exp_q.push_back(rb);
                tick($urandom_range(0, 5));
            end else if (kind == 2) begin
                glen = $urandom_range(1, 6);
                rx = 1'b0;
                tick(glen);
                rx = 1'b1;
                tick(2 * BP);
            end else begin
                send_bits(rb);
                rx = 1'b0;
                tick(BP);
                rx = 1'b1;
                exp_fe++;
                tick(BP);
            end
        end
        tick(BP);
        sample();
        n_exp = exp_q.size();
        chk("rand_count", got_q.size(), n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (i < got_q.size()) chk("rand_byte", got_q[i], exp_q[i]);
        end
        chk("rand_fe", fe_cnt - fe0, exp_fe);
        chk("rand_ov", ov_cnt - ov0, 0);
        chk("rand_vcyc", vcyc - v0, n_exp);
        chk("never_both", both_cnt, 0);
        chk("rand_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
